// File: rtl/uart_rx_cfg_if.sv
// Serial line plus received-word bus for uart_rx_cfg.
// master = the receiver, slave = the consumer that also drives the line and tick.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 b_tick;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        input  rx, b_tick,
        output rx_data, rx_done, parity_err, frame_err, rx_busy
    );

    modport slave (
        output rx, b_tick,
        input  rx_data, rx_done, parity_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled, 3-sample majority vote per bit,
// optional parity, 1/2 stop bits, start-glitch rejection and break recovery.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_cfg_if.master bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SMP0     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP1     = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] VOTE     = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);
    localparam logic ODD       = (PARITY_ODD != 0);
    localparam logic HAS_PAR   = (PARITY_EN != 0);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic [1:0]           sync_q, sync_d;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic rx_s, maj, vote, ferr_now;

    assign rx_s = sync_q[1];
    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign vote = (cnt_q == VOTE);

    always_comb begin
        sync_d       = {sync_q[0], bus.rx};
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        smp_d        = smp_q;
        shreg_d      = shreg_q;
        perr_pend_d  = perr_pend_q;
        ferr_pend_d  = ferr_pend_q;
        rx_data_d    = rx_data_q;
        rx_done_d    = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        ferr_now     = 1'b0;

        if (bus.b_tick) begin
            if (state_q != IDLE && state_q != WAIT_IDLE) begin
                cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
                if (cnt_q == SMP0) smp_d[0] = rx_s;
                if (cnt_q == SMP1) smp_d[1] = rx_s;
            end
            case (state_q)
                IDLE: if (!rx_s) begin
                    state_d     = START;
                    cnt_d       = '0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
                START: begin
                    if (vote && maj) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shift in from the top
                    if (vote) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    if (cnt_q == CNT_MAX) begin
                        if (bit_idx_q == LAST_BIT) begin
                            state_d    = HAS_PAR ? PARITY : STOP;
                            stop_idx_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (vote) perr_pend_d = (^shreg_q) ^ maj ^ ODD;
                    if (cnt_q == CNT_MAX) begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                    end
                end
                STOP: begin
                    if (vote) begin
                        ferr_now    = ferr_pend_q | ~maj;
                        ferr_pend_d = ferr_now;
                        // complete mid-stop so a following start edge is not missed
                        if (stop_idx_q == LAST_STOP) begin
                            rx_done_d    = 1'b1;
                            rx_data_d    = shreg_q;
                            parity_err_d = perr_pend_q;
                            frame_err_d  = ferr_now;
                            state_d      = ferr_now ? WAIT_IDLE : IDLE;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        stop_idx_d = 1'b1;
                    end
                end
                WAIT_IDLE: if (rx_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            smp_q        <= 2'b11;
            shreg_q      <= '0;
            perr_pend_q  <= 1'b0;
            ferr_pend_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            smp_q        <= smp_d;
            shreg_q      <= shreg_d;
            perr_pend_q  <= perr_pend_d;
            ferr_pend_q  <= ferr_pend_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_done    = rx_done_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.rx_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 8E1, 8N2)
// share clock, reset and tick; expected words are queued as frames are driven.
module tb_uart_rx_cfg;
    localparam int TDIV = 4;          // clk per b_tick
    localparam int BITC = 16 * TDIV;  // clk per bit

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic tick;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_def[$], q_par[$], q_s2[$];

    uart_rx_cfg_if #(.DATA_BITS(8)) if_def ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_par ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_s2 ();

    assign if_def.b_tick = tick;
    assign if_par.b_tick = tick;
    assign if_s2.b_tick  = tick;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        u_par (.clk(clk), .rst_n(rst_n), .bus(if_par));
    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u_s2 (.clk(clk), .rst_n(rst_n), .bus(if_s2));

    always #5 clk = ~clk;

    initial begin
        int div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            div  = (div == TDIV - 1) ? 0 : div + 1;
            tick = (div == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int which, input logic v);
        case (which)
            0:       if_def.rx = v;
            1:       if_par.rx = v;
            default: if_s2.rx  = v;
        endcase
    endtask

    // A glitched bit pulls the line low for one tick period near mid-bit
    task automatic drive_bit(input int which, input logic v, input bit glitch);
        if (glitch) begin
            set_rx(which, v);
            repeat (30) @(negedge clk);
            set_rx(which, 1'b0);
            repeat (TDIV) @(negedge clk);
            set_rx(which, v);
            repeat (BITC - 30 - TDIV) @(negedge clk);
        end else begin
            set_rx(which, v);
            repeat (BITC) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input int par,
                              input int nstop, input int gbit);
        logic [7:0] dv;
        dv = d;
        drive_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, dv[i], (i == gbit));
        if (par >= 0) drive_bit(which, par[0], 1'b0);
        for (int i = 0; i < nstop; i++) drive_bit(which, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin : mon_def
        exp_t e;
        if (rst_n && if_def.rx_done) begin
            if (q_def.size() == 0) chk("def_unexpected_done", 1, 0);
            else begin
                e = q_def.pop_front();
                chk("def_data", if_def.rx_data, e.d);
                chk("def_perr", if_def.parity_err, e.p);
                chk("def_ferr", if_def.frame_err, e.f);
            end
        end
    end

    always @(negedge clk) begin : mon_par
        exp_t e;
        if (rst_n && if_par.rx_done) begin
            if (q_par.size() == 0) chk("par_unexpected_done", 1, 0);
            else begin
                e = q_par.pop_front();
                chk("par_data", if_par.rx_data, e.d);
                chk("par_perr", if_par.parity_err, e.p);
                chk("par_ferr", if_par.frame_err, e.f);
            end
        end
    end

    always @(negedge clk) begin : mon_s2
        exp_t e;
        if (rst_n && if_s2.rx_done) begin
            if (q_s2.size() == 0) chk("s2_unexpected_done", 1, 0);
            else begin
                e = q_s2.pop_front();
                chk("s2_data", if_s2.rx_data, e.d);
                chk("s2_perr", if_s2.parity_err, e.p);
                chk("s2_ferr", if_s2.frame_err, e.f);
            end
        end
    end

    // One-clk done: a done seen in two consecutive cycles is an error
    logic prev_done_def = 1'b0;
    always @(negedge clk) begin
        if (rst_n && if_def.rx_done && prev_done_def) chk("def_done_width", 2, 1);
        prev_done_def = if_def.rx_done;
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        if_def.rx = 1'b1;
        if_par.rx = 1'b1;
        if_s2.rx  = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_data", if_def.rx_data, 0);
        chk("rst_done", if_def.rx_done, 0);
        chk("rst_busy", if_def.rx_busy, 0);
        chk("rst_ferr", if_def.frame_err, 0);
        chk("rst_perr", if_par.parity_err, 0);
        rst_n = 1'b1;
        repeat (BITC) @(negedge clk);

        // 8N1 frame
        q_def.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, -1, 1, -1);
        drive_bit(0, 1'b1, 1'b0);
        chk("a5_drained", q_def.size(), 0);
        chk("a5_busy_idle", if_def.rx_busy, 0);

        // start-bit glitch of 3 ticks
        seen = 1'b0;
        if_def.rx = 1'b0;
        repeat (3 * TDIV) begin @(negedge clk); seen |= if_def.rx_busy; end
        if_def.rx = 1'b1;
        repeat (BITC) begin @(negedge clk); seen |= if_def.rx_busy; end
        chk("glitch_busy_seen", seen, 1);
        chk("glitch_busy_idle", if_def.rx_busy, 0);
        chk("glitch_data_kept", if_def.rx_data, 8'hA5);

        // even parity: good then bad parity bit
        q_par.push_back('{8'h3C, 1'b0, 1'b0});
        send_frame(1, 8'h3C, 0, 1, -1);
        drive_bit(1, 1'b1, 1'b0);
        q_par.push_back('{8'h3C, 1'b1, 1'b0});
        send_frame(1, 8'h3C, 1, 1, -1);
        drive_bit(1, 1'b1, 1'b0);
        chk("par_drained", q_par.size(), 0);

        // break: 20 bit times low, then a clean frame
        q_def.push_back('{8'h00, 1'b0, 1'b1});
        if_def.rx = 1'b0;
        repeat (20 * BITC) @(negedge clk);
        chk("break_one_done", q_def.size(), 0);
        chk("break_busy_wait", if_def.rx_busy, 1);
        if_def.rx = 1'b1;
        repeat (2 * BITC) @(negedge clk);
        chk("break_busy_idle", if_def.rx_busy, 0);
        q_def.push_back('{8'h55, 1'b0, 1'b0});
        send_frame(0, 8'h55, -1, 1, -1);
        drive_bit(0, 1'b1, 1'b0);
        chk("x55_drained", q_def.size(), 0);

        // two stop bits, back-to-back, one glitched sample in bit 3
        q_s2.push_back('{8'h00, 1'b0, 1'b0});
        q_s2.push_back('{8'hFF, 1'b0, 1'b0});
        send_frame(2, 8'h00, -1, 2, -1);
        send_frame(2, 8'hFF, -1, 2, 3);
        drive_bit(2, 1'b1, 1'b0);
        chk("s2_drained", q_s2.size(), 0);

        // reset mid-frame during data bit 4 of 0x81
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, (i == 0), 1'b0);
        if_def.rx = 1'b0;
        repeat (BITC / 2) @(negedge clk);
        chk("abort_busy_before", if_def.rx_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_data", if_def.rx_data, 0);
        chk("abort_rst_busy", if_def.rx_busy, 0);
        chk("abort_rst_done", if_def.rx_done, 0);
        chk("abort_rst_ferr", if_def.frame_err, 0);
        chk("abort_rst_perr", if_par.parity_err, 0);
        if_def.rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (BITC) @(negedge clk);
        q_def.push_back('{8'h7E, 1'b0, 1'b0});
        send_frame(0, 8'h7E, -1, 1, -1);
        drive_bit(0, 1'b1, 1'b0);
        chk("x7e_drained", q_def.size(), 0);
        chk("final_busy", if_def.rx_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
